frame_minmax_sequencer: RTL and testbench
=========================================

Name: frame_minmax_sequencer

Overview:
- Time-shares one 4-bit `magnitude_comparator` instance to find the maximum and minimum of a frame of FRAME_LEN samples.
- Samples arrive over a valid/ready stream.
- At frame end the block reports the max value, min value and the index of each.
- Sits between a sample source and downstream decision logic. It is the sequencer for the shared comparator datapath.

Parameters:
- FRAME_LEN, 8, number of samples per frame; legal range 2..2**IDX_W.
- IDX_W, 3, width of the index outputs and the internal sample counter; must satisfy 2**IDX_W >= FRAME_LEN.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- start  input  1  begin a new frame; sampled only in IDLE
- in_valid  input  1  in_data valid
- in_data  input  4  unsigned sample
- in_ready  output  1  block can accept a sample this cycle
- busy  output  1  high in every state except IDLE
- done  output  1  one-cycle pulse: results valid
- max_val  output  4  largest sample of the last frame
- max_idx  output  IDX_W  index (0-based) of first occurrence of max
- min_val  output  4  smallest sample of the last frame
- min_idx  output  IDX_W  index of first occurrence of min

Behaviour:
- Comparator use:
  - One internal `magnitude_comparator` instance (a, b, a_gt_b, a_eq_b, a_lt_b).
  - a = sample register.
  - b = max register in CMP_MAX, min register in CMP_MIN, 0 otherwise.
  - No second comparator is permitted.
- Reset (rst_n low, async):
  - state=IDLE.
  - in_ready, busy, done = 0.
  - max_val, min_val, max_idx, min_idx, sample register, counter = 0.
- FSM states: IDLE, WAIT, CMP_MAX, CMP_MIN, DONE.
- IDLE:
  - busy=0.
  - start=1 -> WAIT, counter cleared.
  - Results from the previous frame are held.
- WAIT:
  - in_ready=1, combinational from state only.
  - On in_valid & in_ready, in_data is captured into the sample register.
  - Counter==0 (first sample):
    - max_val=min_val=in_data, max_idx=min_idx=0.
    - counter becomes 1; stay in WAIT.
  - Counter!=0: -> CMP_MAX.
  - in_valid low: stay in WAIT indefinitely.
- CMP_MAX:
  - in_ready=0.
  - If a_gt_b: max_val=sample, max_idx=counter.
  - -> CMP_MIN.
- CMP_MIN:
  - in_ready=0.
  - If a_lt_b: min_val=sample, min_idx=counter.
  - If counter==FRAME_LEN-1 -> DONE; else counter+1 and -> WAIT.
- DONE:
  - done=1 for exactly this one cycle.
  - Results are stable in this cycle and stay unchanged until the next frame's first sample is accepted.
  - -> IDLE unconditionally.
- Ties use strict comparisons only:
  - An equal sample never updates max or min.
  - The index reported is always the earliest occurrence.
- Throughput: one sample per 3 cycles maximum (first sample: 1 cycle).
- Latency: the last sample is accepted at edge k; done is high in the cycle following edge k+2.
- start outside IDLE is ignored; it has no effect on an in-progress frame.
- start in the DONE cycle is ignored. A new frame needs start in IDLE, so back-to-back frames have at least 1 idle cycle.
- Reset mid-frame aborts immediately:
  - All state and outputs return to reset values.
  - A partial frame produces no done.
- Counter never exceeds FRAME_LEN-1; no wrap is possible.

Test Plan:
- Reset, start, frame 3,9,1,9,0,15,7,2 with in_valid held high -> single done pulse; max_val=15, max_idx=5, min_val=0, min_idx=4; done is 3 cycles after the last handshake.
- Frame of eight 5s -> max_val=min_val=5, max_idx=min_idx=0 (tie keeps earliest).
- Frame 4,4,3,4,3,8,8,3 with in_valid toggled randomly -> in_ready low in CMP_MAX/CMP_MIN; no sample lost or duplicated; max=8 at index 5, min=3 at index 2.
- Pulse start while busy mid-frame -> counter and results unaffected; exactly one done for the frame.
- Assert rst_n low after 4 samples -> all outputs 0 asynchronously, no done. A following full frame 0..7 gives max=7 at idx 7, min=0 at idx 0.
- Two consecutive frames (descending 15..8, then ascending 1..8) -> second done reports max=8 at idx 7, min=1 at idx 0; first-frame results are held until the second frame's first sample is accepted.

Source files
------------

// File: rtl/frame_minmax_sequencer.sv
// Frame max/min finder: one shared 4-bit magnitude comparator, sequenced by a
// five-state FSM over a valid/ready sample stream.

module magnitude_comparator (
    input  logic [3:0] a,
    input  logic [3:0] b,
    output logic       a_gt_b,
    output logic       a_eq_b,
    output logic       a_lt_b
);
    assign a_gt_b = (a > b);
    assign a_eq_b = (a == b);
    assign a_lt_b = (a < b);
endmodule

module frame_minmax_sequencer #(
    parameter int FRAME_LEN = 8,
    parameter int IDX_W     = 3
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             in_valid,
    input  logic [3:0]       in_data,
    output logic             in_ready,
    output logic             busy,
    output logic             done,
    output logic [3:0]       max_val,
    output logic [IDX_W-1:0] max_idx,
    output logic [3:0]       min_val,
    output logic [IDX_W-1:0] min_idx
);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(FRAME_LEN - 1);
    localparam logic [IDX_W-1:0] IDX_ZERO = {IDX_W{1'b0}};
    localparam logic [IDX_W-1:0] IDX_ONE  = {{(IDX_W-1){1'b0}}, 1'b1};

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_WAIT    = 3'd1,
        ST_CMP_MAX = 3'd2,
        ST_CMP_MIN = 3'd3,
        ST_DONE    = 3'd4
    } state_t;

    state_t           state_r;
    logic [IDX_W-1:0] cnt_r;
    logic [3:0]       sample_r;
    logic [3:0]       max_val_r;
    logic [3:0]       min_val_r;
    logic [IDX_W-1:0] max_idx_r;
    logic [IDX_W-1:0] min_idx_r;

    logic [3:0]       cmp_b_s;
    logic             a_gt_b_s;
    logic             a_eq_b_s;
    logic             a_lt_b_s;

    // Comparator operand b follows the phase: running max, running min, else zero.
    always_comb begin
        cmp_b_s = 4'd0;
        case (state_r)
            ST_CMP_MAX: cmp_b_s = max_val_r;
            ST_CMP_MIN: cmp_b_s = min_val_r;
            default:    cmp_b_s = 4'd0;
        endcase
    end

    magnitude_comparator u_cmp (
        .a      (sample_r),
        .b      (cmp_b_s),
        .a_gt_b (a_gt_b_s),
        .a_eq_b (a_eq_b_s),
        .a_lt_b (a_lt_b_s)
    );

    // Sequencer: capture samples, then one comparison phase each for max and min.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r   <= ST_IDLE;
            cnt_r     <= IDX_ZERO;
            sample_r  <= 4'd0;
            max_val_r <= 4'd0;
            min_val_r <= 4'd0;
            max_idx_r <= IDX_ZERO;
            min_idx_r <= IDX_ZERO;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (start) begin
                        cnt_r   <= IDX_ZERO;
                        state_r <= ST_WAIT;
                    end else begin
                        state_r <= ST_IDLE;
                    end
                end
                ST_WAIT: begin
                    if (in_valid) begin
                        sample_r <= in_data;
                        if (cnt_r == IDX_ZERO) begin
                            // First sample seeds both extremes; no comparison needed.
                            max_val_r <= in_data;
                            min_val_r <= in_data;
                            max_idx_r <= IDX_ZERO;
                            min_idx_r <= IDX_ZERO;
                            cnt_r     <= IDX_ONE;
                            state_r   <= ST_WAIT;
                        end else begin
                            state_r <= ST_CMP_MAX;
                        end
                    end else begin
                        state_r <= ST_WAIT;
                    end
                end
                ST_CMP_MAX: begin
                    // Strict greater-than keeps the earliest index on ties.
                    if (a_gt_b_s && !a_eq_b_s) begin
                        max_val_r <= sample_r;
                        max_idx_r <= cnt_r;
                    end else begin
                        max_val_r <= max_val_r;
                    end
                    state_r <= ST_CMP_MIN;
                end
                ST_CMP_MIN: begin
                    if (a_lt_b_s) begin
                        min_val_r <= sample_r;
                        min_idx_r <= cnt_r;
                    end else begin
                        min_val_r <= min_val_r;
                    end
                    if (cnt_r == LAST_IDX) begin
                        state_r <= ST_DONE;
                    end else begin
                        cnt_r   <= cnt_r + IDX_ONE;
                        state_r <= ST_WAIT;
                    end
                end
                ST_DONE: begin
                    state_r <= ST_IDLE;
                end
                default: begin
                    state_r <= ST_IDLE;
                end
            endcase
        end
    end

    assign in_ready = (state_r == ST_WAIT);
    assign busy     = (state_r != ST_IDLE);
    assign done     = (state_r == ST_DONE);
    assign max_val  = max_val_r;
    assign min_val  = min_val_r;
    assign max_idx  = max_idx_r;
    assign min_idx  = min_idx_r;

endmodule

// File: tb/tb_frame_minmax_sequencer.sv
// Directed bench for frame_minmax_sequencer with hand-computed frame results.

module tb_frame_minmax_sequencer;
    logic       clk;
    logic       rst_n;
    logic       start;
    logic       in_valid;
    logic [3:0] in_data;
    logic       in_ready;
    logic       busy;
    logic       done;
    logic [3:0] max_val;
    logic [2:0] max_idx;
    logic [3:0] min_val;
    logic [2:0] min_idx;

    int         n_checks;
    int         n_errors;
    int         done_cnt;
    logic [3:0] frame_d [0:7];

    frame_minmax_sequencer #(.FRAME_LEN(8), .IDX_W(3)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .in_valid (in_valid),
        .in_data  (in_data),
        .in_ready (in_ready),
        .busy     (busy),
        .done     (done),
        .max_val  (max_val),
        .max_idx  (max_idx),
        .min_val  (min_val),
        .min_idx  (min_idx)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Count done pulses, sampled away from the active edge.
    always @(negedge clk) begin
        if (done) done_cnt <= done_cnt + 1;
    end

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic check_results(input string tag, input int mx, input int mxi, input int mn, input int mni);
        check_val({tag, "_max"},  32'(max_val), 32'(mx));
        check_val({tag, "_maxi"}, 32'(max_idx), 32'(mxi));
        check_val({tag, "_min"},  32'(min_val), 32'(mn));
        check_val({tag, "_mini"}, 32'(min_idx), 32'(mni));
    endtask

    task automatic begin_frame();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check_val("wait_ready", 32'(in_ready), 32'd1);
    endtask

    // Feed frame_d[from..to]; returns at the negedge just after the last handshake edge.
    task automatic send_samples(input int from, input int to, input bit rand_valid,
                                input int start_at, input bit chk_rdy);
        bit hs;
        int guard;
        for (int i = from; i <= to; i++) begin
            in_data = frame_d[i];
            hs      = 1'b0;
            guard   = 0;
            while (!hs && guard < 50) begin
                in_valid = rand_valid ? 1'($urandom_range(0, 1)) : 1'b1;
                start    = (i == start_at);
                hs       = in_valid && in_ready;
                @(negedge clk);
                guard++;
            end
            start = 1'b0;
            if (!hs) check_val("hs_timeout", 32'd0, 32'd1);
            if (chk_rdy && i > 0) check_val("rdy_in_cmp", 32'(in_ready), 32'd0);
        end
        in_valid = 1'b0;
    endtask

    task automatic finish_frame(input string tag, input int mx, input int mxi, input int mn, input int mni);
        int d0;
        d0 = done_cnt;
        check_val({tag, "_nodone_cmpmax"}, 32'(done), 32'd0);
        @(negedge clk);
        check_val({tag, "_nodone_cmpmin"}, 32'(done), 32'd0);
        @(negedge clk);
        check_val({tag, "_done"}, 32'(done), 32'd1);
        check_results(tag, mx, mxi, mn, mni);
        @(negedge clk);
        check_val({tag, "_done_low"}, 32'(done), 32'd0);
        check_val({tag, "_idle"}, 32'(busy), 32'd0);
        check_val({tag, "_one_done"}, 32'(done_cnt - d0), 32'd1);
        check_results({tag, "_held"}, mx, mxi, mn, mni);
    endtask

    task automatic load(input logic [31:0] packed_d);
        for (int i = 0; i < 8; i++) frame_d[i] = packed_d[31 - 4*i -: 4];
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        done_cnt = 0;
        rst_n    = 1'b0;
        start    = 1'b0;
        in_valid = 1'b0;
        in_data  = 4'd0;
        #12;
        check_val("rst_ready", 32'(in_ready), 32'd0);
        check_val("rst_busy",  32'(busy),     32'd0);
        check_val("rst_done",  32'(done),     32'd0);
        check_results("rst", 0, 0, 0, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check_val("idle_busy", 32'(busy), 32'd0);

        // Mixed frame with repeated 9 and extremes mid-frame.
        load(32'h3919_0F72);
        begin_frame();
        check_val("start_busy", 32'(busy), 32'd1);
        send_samples(0, 7, 1'b0, -1, 1'b1);
        finish_frame("f1", 15, 5, 0, 4);

        // All-equal frame: earliest index wins.
        @(negedge clk);
        load(32'h5555_5555);
        begin_frame();
        send_samples(0, 7, 1'b0, -1, 1'b0);
        finish_frame("f2", 5, 0, 5, 0);

        // Random valid gaps with ties.
        @(negedge clk);
        load(32'h4434_3883);
        begin_frame();
        send_samples(0, 7, 1'b1, -1, 1'b1);
        finish_frame("f3", 8, 5, 3, 2);

        // start pulsed while busy must not disturb the frame.
        @(negedge clk);
        load(32'h62B2_B1C1);
        begin_frame();
        send_samples(0, 7, 1'b0, 3, 1'b0);
        finish_frame("f4", 12, 6, 1, 5);

        // Abort mid-frame with async reset, then a full ascending frame.
        @(negedge clk);
        load(32'h3919_0F72);
        begin_frame();
        begin
            int d0;
            d0 = done_cnt;
            send_samples(0, 3, 1'b0, -1, 1'b0);
            #2 rst_n = 1'b0;
            #1;
            check_val("abort_busy",  32'(busy),     32'd0);
            check_val("abort_ready", 32'(in_ready), 32'd0);
            check_results("abort", 0, 0, 0, 0);
            @(negedge clk);
            rst_n = 1'b1;
            repeat (4) @(negedge clk);
            check_val("abort_nodone", 32'(done_cnt - d0), 32'd0);
        end
        load(32'h0123_4567);
        begin_frame();
        send_samples(0, 7, 1'b0, -1, 1'b0);
        finish_frame("f5", 7, 7, 0, 0);

        // Back-to-back frames: results held until the next first sample.
        @(negedge clk);
        load(32'hFEDC_BA98);
        begin_frame();
        send_samples(0, 7, 1'b0, -1, 1'b0);
        finish_frame("f6", 15, 0, 8, 7);
        load(32'h1234_5678);
        begin_frame();
        check_results("f7_prehold", 15, 0, 8, 7);
        send_samples(0, 0, 1'b0, -1, 1'b0);
        check_results("f7_first", 1, 0, 1, 0);
        send_samples(1, 7, 1'b0, -1, 1'b0);
        finish_frame("f7", 8, 7, 1, 0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

    // Global watchdog so the run always terminates.
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "timeout");
    end

endmodule
